div_tick_sequencer: RTL
=======================

Name: div_tick_sequencer

Overview:
Run/stop controller for a programmable divide-by-N tick generator. Produces a one-cycle `tick` clock-enable every N cycles while running, either free-running or for a programmed burst of ticks. A valid/ready handshake updates the divisor and burst length; updates made while running are staged and applied at the next period boundary. Sits between control software and the datapath blocks it paces.

Parameters:
- CNT_W, 8, width of divisor and period counter.
- BURST_W, 8, width of burst length and remaining-tick counter.
- DEF_DIV, 3, active divisor after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- cfg_valid  input  1  configuration offered.
- cfg_ready  output  1  configuration can be accepted this cycle.
- cfg_div  input  CNT_W  divisor N; 0 is treated as 1.
- cfg_burst  input  BURST_W  tick count per run; 0 means free-run.
- start  input  1  begin a run (sampled).
- stop  input  1  abort a run (sampled).
- tick  output  1  one-cycle enable pulse, Moore.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- States: IDLE, RUN, DONE; 2-bit encoding, registered.
- Reset values (asynchronous):
  - state = IDLE; cnt = 0; remaining = 0.
  - active_div = DEF_DIV; active_burst = 0; shadow_valid = 0.
  - Outputs: tick = 0, busy = 0, done = 0, cfg_ready = 1.
- Configuration handshake:
  - A transfer happens on any edge where cfg_valid && cfg_ready.
  - IDLE or DONE: cfg_ready = 1. A transfer writes active_div and active_burst directly.
  - RUN: cfg_ready = !shadow_valid. A transfer writes the shadow registers and sets shadow_valid.
  - When shadow_valid and a tick cycle occurs, the shadow is copied to active on that edge and shadow_valid clears. The reload uses the new divisor; remaining reloads from the new burst.
  - Divisor normalisation: div_eff = max(div, 1).
- IDLE:
  - start && !stop -> RUN; cnt <= div_eff - 1; remaining <= active_burst.
  - A config transfer on the same edge as start is used by that run.
  - stop, or start && stop -> stay IDLE.
- RUN:
  - busy = 1; tick = (cnt == 0).
  - Non-tick cycle: cnt decrements.
  - Tick cycle: cnt <= div_eff - 1, using the post-shadow-apply divisor.
  - Burst mode (burst != 0): remaining decrements on each tick. On the tick where remaining == 1, the next state is DONE.
  - Free-run (burst == 0): no termination.
  - stop sampled -> IDLE next edge. A tick asserted in the same cycle as stop is still emitted (Moore). Shadow is discarded; shadow_valid clears.
  - start in RUN is ignored.
- DONE:
  - done = 1, busy = 0, tick = 0, for one cycle, then IDLE.
  - start in DONE is ignored.
- Latency: start sampled at edge E0 -> first tick in the cycle after edge E0 + (div_eff - 1). Div 3: tick in the 3rd cycle after start. Div 1: tick in every RUN cycle.
- Reset mid-run: immediate return to IDLE; any staged shadow is lost.
- Counters do not wrap. cnt never decrements below 0 and remaining never below 1 in RUN.

Optional Feature:
- Macro: DTS_AUTO_RELOAD_EN.
- Defined: on burst completion, DONE lasts one cycle and then returns to RUN instead of IDLE. cnt reloads to div_eff - 1 and remaining reloads to active_burst, with the shadow applied if valid. done still pulses once per burst. stop in DONE -> IDLE.
- Undefined: DONE -> IDLE as above.

Test Plan:
- Reset, then start with defaults (div 3, burst 0) -> tick every 3rd cycle (pattern 0,0,1 repeating); busy = 1; done never asserts.
- Config div=5, burst=2 in IDLE, then start -> ticks in cycles 5 and 10 after start; done pulses in cycle 11; busy = 0 from cycle 11.
- Running with div=4: transfer cfg_div=2 mid-period -> cfg_ready drops until the next tick. The period in progress stays 4; the following periods are 2.
- cfg_div=0 and cfg_div=1 -> tick on every RUN cycle; stop issued during a tick cycle -> tick still high that cycle, IDLE next cycle.
- start && stop in IDLE -> stays IDLE; reset asserted mid-run -> tick/busy/done = 0 immediately, cfg_ready = 1.
- With DTS_AUTO_RELOAD_EN, div=2, burst=3 -> repeating ticks in cycles 2, 4, 6 of each burst, done in cycle 7, next burst's ticks in cycles 9, 11, 13.

Source files
------------

// File: rtl/div_tick_sequencer.sv
// Purpose : run/stop controller for a programmable divide-by-N tick (clock-enable) generator.
// Latency : first tick div_eff cycles after start is sampled; tick/busy/done are Moore (registered state).
// Backpressure: cfg_ready drops in RUN while a staged update waits for the next period boundary.
//
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   cfg_valid/cfg_ready    - configuration handshake; cfg_div (0 treated as 1), cfg_burst (0 = free-run)
//   start, stop            - begin / abort a run (sampled on clk)
//   tick                   - one-cycle enable pulse every div_eff cycles while running
//   busy                   - high while in RUN
//   done                   - one-cycle pulse when a burst completes
//
// Optional feature macro: DTS_AUTO_RELOAD_EN
//   defined   : after a completed burst, DONE returns to RUN and a new burst starts (stop in DONE -> IDLE)
//   undefined : DONE always returns to IDLE
module div_tick_sequencer #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8,
    parameter int DEF_DIV = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               tick,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [BURST_W-1:0]   r_remaining;
    logic [CNT_W-1:0]     r_active_div;
    logic [BURST_W-1:0]   r_active_burst;
    logic [CNT_W-1:0]     r_shadow_div;
    logic [BURST_W-1:0]   r_shadow_burst;
    logic                 r_shadow_valid;

    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [BURST_W-1:0]   w_remaining_nxt;
    logic [CNT_W-1:0]     w_active_div_nxt;
    logic [BURST_W-1:0]   w_active_burst_nxt;
    logic [CNT_W-1:0]     w_shadow_div_nxt;
    logic [BURST_W-1:0]   w_shadow_burst_nxt;
    logic                 w_shadow_valid_nxt;

    logic                 w_xfer;
    logic                 w_tick;
    logic [CNT_W-1:0]     w_div_sel;
    logic [BURST_W-1:0]   w_burst_sel;

    // Divide-by-0 behaves as divide-by-1.
    function automatic logic [CNT_W-1:0] f_div_eff(input logic [CNT_W-1:0] d);
        return (d == '0) ? CNT_W'(1) : d;
    endfunction

    assign cfg_ready = (r_state != S_RUN) || !r_shadow_valid;
    assign w_xfer    = cfg_valid && cfg_ready;
    assign w_tick    = (r_state == S_RUN) && (r_cnt == '0);
    assign tick      = w_tick;
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);

    // Divisor/burst a run (re)start should use outside RUN: a same-edge transfer wins,
    // then any update staged during the run that just finished, then the active values.
    always_comb begin
        w_div_sel   = r_active_div;
        w_burst_sel = r_active_burst;
        if (w_xfer) begin
            w_div_sel   = cfg_div;
            w_burst_sel = cfg_burst;
        end else if (r_shadow_valid) begin
            w_div_sel   = r_shadow_div;
            w_burst_sel = r_shadow_burst;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_remaining    <= '0;
            r_active_div   <= CNT_W'(DEF_DIV);
            r_active_burst <= '0;
            r_shadow_div   <= '0;
            r_shadow_burst <= '0;
            r_shadow_valid <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_remaining    <= w_remaining_nxt;
            r_active_div   <= w_active_div_nxt;
            r_active_burst <= w_active_burst_nxt;
            r_shadow_div   <= w_shadow_div_nxt;
            r_shadow_burst <= w_shadow_burst_nxt;
            r_shadow_valid <= w_shadow_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_remaining_nxt    = r_remaining;
        w_active_div_nxt   = r_active_div;
        w_active_burst_nxt = r_active_burst;
        w_shadow_div_nxt   = r_shadow_div;
        w_shadow_burst_nxt = r_shadow_burst;
        w_shadow_valid_nxt = r_shadow_valid;

        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_active_div_nxt   = cfg_div;
                    w_active_burst_nxt = cfg_burst;
                end
                if (start && !stop) begin
                    w_state_nxt     = S_RUN;
                    w_cnt_nxt       = f_div_eff(w_div_sel) - CNT_W'(1);
                    w_remaining_nxt = w_burst_sel;
                end
            end

            S_RUN: begin
                if (w_xfer) begin
                    w_shadow_div_nxt   = cfg_div;
                    w_shadow_burst_nxt = cfg_burst;
                    w_shadow_valid_nxt = 1'b1;
                end
                if (stop) begin
                    // Abort discards any staged update, including one offered this cycle.
                    w_state_nxt        = S_IDLE;
                    w_cnt_nxt          = '0;
                    w_remaining_nxt    = '0;
                    w_shadow_valid_nxt = 1'b0;
                end else if (w_tick) begin
                    if (r_shadow_valid) begin
                        // Period boundary: the staged update takes over and restarts the burst count.
                        w_active_div_nxt   = r_shadow_div;
                        w_active_burst_nxt = r_shadow_burst;
                        w_shadow_valid_nxt = 1'b0;
                        w_cnt_nxt          = f_div_eff(r_shadow_div) - CNT_W'(1);
                        w_remaining_nxt    = r_shadow_burst;
                    end else begin
                        w_cnt_nxt = f_div_eff(r_active_div) - CNT_W'(1);
                        if (r_active_burst != '0) begin
                            if (r_remaining == BURST_W'(1)) begin
                                w_state_nxt     = S_DONE;
                                w_remaining_nxt = '0;
                            end else begin
                                w_remaining_nxt = r_remaining - BURST_W'(1);
                            end
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            S_DONE: begin
                // An update staged on the final tick edge is folded in here.
                w_active_div_nxt   = w_div_sel;
                w_active_burst_nxt = w_burst_sel;
                w_shadow_valid_nxt = 1'b0;
`ifdef DTS_AUTO_RELOAD_EN
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt     = S_RUN;
                    w_cnt_nxt       = f_div_eff(w_div_sel) - CNT_W'(1);
                    w_remaining_nxt = w_burst_sel;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
